// File: rtl/axis_byte_packer_if.sv
// Stream bundle for the byte packer: narrow s_* input side and double-width m_* output side.
// The packer binds the slave view for its input and the master view for its output.
interface axis_byte_packer_if #(
  parameter int IN_WIDTH = 8
);
  logic [IN_WIDTH-1:0]   s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;
  logic                  s_tlast;
  logic                  s_tuser;
  logic [2*IN_WIDTH-1:0] m_tdata;
  logic [1:0]            m_tkeep;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic                  m_tuser;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser,
    output s_tready
  );

  modport master (
    output m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser,
    input  m_tready
  );
endinterface

// File: rtl/axis_byte_packer.sv
// Packs pairs of narrow AXI-Stream beats into one double-width word, first beat in the low lane.
// A lone trailing beat (tlast while EMPTY) goes out as a half word with only the low keep bit set.
module axis_byte_packer #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  axis_byte_packer_if.slave   s_if,
  axis_byte_packer_if.master  m_if,
  output logic                dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // Valid never waits on ready; s_tready depends only on the output register and m_tready.

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic                  hold_user_q, hold_user_d;
  logic [2*IN_WIDTH-1:0] tdata_q, tdata_d;
  logic [1:0]            tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  s_ready;
  logic                  accept;

  // Ready whenever the output register is empty or draining this edge.
  assign s_ready = !rst && (!tvalid_q || m_if.m_tready);
  assign accept  = s_if.s_tvalid && s_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_user_d = hold_user_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;

    if (tvalid_q && m_if.m_tready) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        EMPTY: begin
          if (s_if.s_tlast) begin
            tdata_d  = {{IN_WIDTH{1'b0}}, s_if.s_tdata};
            tkeep_d  = 2'b01;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = s_if.s_tuser;
          end else begin
            hold_d      = s_if.s_tdata;
            hold_user_d = s_if.s_tuser;
            state_d     = HALF;
          end
        end
        HALF: begin
          tdata_d  = {s_if.s_tdata, hold_q};
          tkeep_d  = 2'b11;
          tvalid_d = 1'b1;
          tlast_d  = s_if.s_tlast;
          tuser_d  = hold_user_q | s_if.s_tuser;
          state_d  = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      hold_user_q <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= 2'b00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_user_q <= hold_user_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign s_if.s_tready = s_ready;
  assign m_if.m_tdata  = tdata_q;
  assign m_if.m_tkeep  = tkeep_q;
  assign m_if.m_tvalid = tvalid_q;
  assign m_if.m_tlast  = tlast_q;
  assign m_if.m_tuser  = tuser_q;
  assign dbg_state     = (state_q == HALF);

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer: a vector table for streaming packets plus hand-written
// sequences for back-pressure and mid-packet reset; output words are checked by a scoreboard.
module tb_axis_byte_packer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  axis_byte_packer_if #(.IN_WIDTH(W)) bus ();

  axis_byte_packer #(.IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_if      (bus),
    .m_if      (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Word record: {tdata[15:0], tkeep[1:0], tlast, tuser}
  logic [19:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && bus.m_tvalid && bus.m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {12'h0, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tuser}, 32'hFFFFFFFF);
      end else begin
        chk("word", {12'h0, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tuser}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+1; drives one beat and waits (bounded) for its handshake.
  task automatic send(input logic [7:0] d, input logic l, input logic u, output int waits);
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.s_tuser  = u;
    bus.s_tvalid = 1'b1;
    waits = 0;
    while (!bus.s_tready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!bus.s_tready) chk("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        user;
    logic        word;
    logic        half;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] d, logic l, logic u, logic wd, logic h, logic [19:0] e);
    vec_t v;
    v.data = d; v.last = l; v.user = u; v.word = wd; v.half = h; v.exp = e;
    return v;
  endfunction

  int waits;

  initial begin
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.m_tready = 1'b1;

    // Two-beat packet, single odd beat, 8-beat stream, tuser merge, tuser single, tlast=0 word + odd tail.
    vecs.push_back(mk(8'h71, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h69, 1, 0, 1, 0, {16'h6971, 2'b11, 1'b1, 1'b0}));
    vecs.push_back(mk(8'hA5, 1, 0, 1, 0, {16'h00A5, 2'b01, 1'b1, 1'b0}));
    vecs.push_back(mk(8'h01, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h02, 0, 0, 1, 0, {16'h0201, 2'b11, 1'b0, 1'b0}));
    vecs.push_back(mk(8'h03, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h04, 0, 0, 1, 0, {16'h0403, 2'b11, 1'b0, 1'b0}));
    vecs.push_back(mk(8'h05, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h06, 0, 0, 1, 0, {16'h0605, 2'b11, 1'b0, 1'b0}));
    vecs.push_back(mk(8'h07, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h08, 1, 0, 1, 0, {16'h0807, 2'b11, 1'b1, 1'b0}));
    vecs.push_back(mk(8'h33, 0, 1, 0, 1, 20'h0));
    vecs.push_back(mk(8'h44, 1, 0, 1, 0, {16'h4433, 2'b11, 1'b1, 1'b1}));
    vecs.push_back(mk(8'h5A, 1, 1, 1, 0, {16'h005A, 2'b01, 1'b1, 1'b1}));
    vecs.push_back(mk(8'h80, 0, 0, 0, 1, 20'h0));
    vecs.push_back(mk(8'h7F, 0, 1, 1, 0, {16'h7F80, 2'b11, 1'b0, 1'b1}));
    vecs.push_back(mk(8'hC3, 1, 0, 1, 0, {16'h00C3, 2'b01, 1'b1, 1'b0}));

    // Reset values, before any clock edge.
    #1;
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(bus.m_tdata),  32'd0);
    chk("rst_m_tkeep",  32'(bus.m_tkeep),  32'd0);
    chk("rst_m_tlast",  32'(bus.m_tlast),  32'd0);
    chk("rst_m_tuser",  32'(bus.m_tuser),  32'd0);
    chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
    chk("rst_state",    32'(dbg_state),    32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_s_tready", 32'(bus.s_tready), 32'd1);
    @(posedge clk); #1;

    // ---------- table-driven stream with m_tready high ----------
    foreach (vecs[i]) begin
      if (vecs[i].word) exp_q.push_back(vecs[i].exp);
      send(vecs[i].data, vecs[i].last, vecs[i].user, waits);
      chk($sformatf("no_bubble_%0d", i), 32'(waits), 32'd0);
      chk($sformatf("latency_valid_%0d", i), 32'(bus.m_tvalid), 32'(vecs[i].word));
      chk($sformatf("state_%0d", i), 32'(dbg_state), 32'(vecs[i].half));
      chk($sformatf("s_tready_%0d", i), 32'(bus.s_tready), 32'd1);
    end
    @(posedge clk); #1;
    chk("idle_valid", 32'(bus.m_tvalid), 32'd0);

    // ---------- back-pressure: word held stable for 10 cycles ----------
    bus.m_tready = 1'b0;
    exp_q.push_back({16'h2010, 2'b11, 1'b1, 1'b0});
    send(8'h10, 0, 0, waits);
    send(8'h20, 1, 0, waits);
    exp_q.push_back({16'h0099, 2'b01, 1'b1, 1'b0});
    bus.s_tdata  = 8'h99;
    bus.s_tlast  = 1'b1;
    bus.s_tuser  = 1'b0;
    bus.s_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("stall_s_tready", 32'(bus.s_tready), 32'd0);
      chk("stall_word", {12'h0, bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tuser},
          {12'h0, 1'b1, 16'h2010, 2'b11, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    bus.m_tready = 1'b1;
    #1;
    chk("ready_same_cycle", 32'(bus.s_tready), 32'd1);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    chk("drain_load_valid", 32'(bus.m_tvalid), 32'd1);
    chk("drain_load_data",  32'(bus.m_tdata),  32'h0099);
    @(posedge clk); #1;

    // ---------- reset while a word is stalled ----------
    bus.m_tready = 1'b0;
    send(8'hEE, 1, 1, waits);
    chk("stalled_before_rst", 32'(bus.m_tvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pending_valid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_pending_data",  32'(bus.m_tdata),  32'd0);
    chk("rst_pending_user",  32'(bus.m_tuser),  32'd0);
    bus.m_tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------- reset while HALF ----------
    send(8'h11, 0, 1, waits);
    chk("half_before_rst", 32'(dbg_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_half_state",   32'(dbg_state),    32'd0);
    chk("rst_half_valid",   32'(bus.m_tvalid), 32'd0);
    chk("rst_half_s_tready", 32'(bus.s_tready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({16'h3322, 2'b11, 1'b1, 1'b0});
    send(8'h22, 0, 0, waits);
    chk("after_rst_half", 32'(dbg_state), 32'd1);
    send(8'h33, 1, 0, waits);
    chk("after_rst_word", 32'(bus.m_tdata), 32'h3322);

    // ---------- drain ----------
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
